// File: rtl/conv2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_pkg
// Description : Shared defaults for the conv2d3x3 pipeline. Holds the default
//               image geometry, the 3x3 window element indices (k = 3*r + c,
//               r0 = top/oldest row, c0 = left/oldest column) and a helper
//               that slices one element out of a flat window word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package conv2d_pkg;

  localparam int DEF_IMG_SIZE        = 100;
  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_COL_COUNT_WIDTH = 7;

  // Window element indices, row-major from the top-left corner.
  localparam int W_TL = 0;
  localparam int W_TM = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MM = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BM = 7;
  localparam int W_BR = 8;

  // Extract element k from a flat window built with the default pixel width.
  function automatic logic [DEF_DATA_WIDTH-1:0] win_elem(
    input logic [9*DEF_DATA_WIDTH-1:0] win,
    input int unsigned                 k
  );
    return win[k*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
  endfunction

endpackage : conv2d_pkg
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv_line_buffer
// Description : One image row of pixel storage. Combinational read and
//               synchronous write share a single address, so a read-then-
//               write of the same column happens on one edge. Storage is
//               intentionally not reset.
// Ports       : Clk     - clock
//               We_i    - write enable
//               Addr_i  - column address (read and write)
//               Wdata_i - pixel to store
//               Rdata_o - pixel currently stored at Addr_i
// Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
  parameter int DEPTH      = 100,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  Clk,
  input  logic                  We_i,
  input  logic [ADDR_WIDTH-1:0] Addr_i,
  input  logic [DATA_WIDTH-1:0] Wdata_i,
  output logic [DATA_WIDTH-1:0] Rdata_o
);

  // Only the bits needed to span DEPTH entries address the storage.
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [c_IDX_W-1:0]    w_idx;

  assign w_idx   = Addr_i[c_IDX_W-1:0];
  assign Rdata_o = mem_q[w_idx];

  always_ff @(posedge Clk) begin
    if (We_i) begin
      mem_q[w_idx] <= Wdata_i;
    end
  end

endmodule : conv_line_buffer
`default_nettype wire

// File: rtl/conv_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_3x3
// Description : Streaming 3x3 window generator. Accepts one raster pixel per
//               En cycle, keeps the two previous rows in line buffers and
//               presents the current neighbourhood as one flat word.
//               Window_Valid = Row_Valid & (column >= 2), registered with
//               the window on the accepting edge.
// Build macro : CONV_WIN_FRAME_DONE_EN - compiles in the row counter and the
//               Frame_Done pulse; when undefined Frame_Done is tied low.
// Ports       : Clk          - clock, rising edge
//               Rst          - asynchronous active-low reset
//               En           - pixel strobe
//               Pixel_In     - current raster pixel
//               Row_Valid    - row-stage flag for the current row
//               Window_Out   - element k=3*r+c at [DW*(k+1)-1:DW*k]
//               Window_Valid - one-cycle flag, window is interior
//               Frame_Done   - one-cycle pulse on the last pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_3x3
  import conv2d_pkg::*;
#(
  parameter int IMG_SIZE        = DEF_IMG_SIZE,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int COL_COUNT_WIDTH = DEF_COL_COUNT_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    En,
  input  logic [DATA_WIDTH-1:0]   Pixel_In,
  input  logic                    Row_Valid,
  output logic [9*DATA_WIDTH-1:0] Window_Out,
  output logic                    Window_Valid,
  output logic                    Frame_Done
);

  localparam int                   DW          = DATA_WIDTH;
  localparam int                   CW          = COL_COUNT_WIDTH;
  localparam logic [CW-1:0]        c_LAST      = CW'(IMG_SIZE - 1);
  localparam logic [CW-1:0]        c_COL_TWO   = CW'(2);
  localparam logic [CW-1:0]        c_ONE       = CW'(1);

  logic [9*DW-1:0] win_q,   win_d;
  logic [CW-1:0]   col_q,   col_d;
  logic            valid_q, valid_d;

  logic [DW-1:0]   w_mid;      // same column, previous row
  logic [DW-1:0]   w_top;      // same column, two rows back
  logic            w_col_last;

  assign w_col_last = (col_q == c_LAST);

  // LB0 holds the previous row; LB1 the row before. On each accepted pixel
  // LB1 takes LB0's old value at this column while LB0 takes the new pixel.
  conv_line_buffer #(
    .DEPTH      (IMG_SIZE),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (CW)
  ) u_lb0 (
    .Clk     (Clk),
    .We_i    (En),
    .Addr_i  (col_q),
    .Wdata_i (Pixel_In),
    .Rdata_o (w_mid)
  );

  conv_line_buffer #(
    .DEPTH      (IMG_SIZE),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (CW)
  ) u_lb1 (
    .Clk     (Clk),
    .We_i    (En),
    .Addr_i  (col_q),
    .Wdata_i (w_mid),
    .Rdata_o (w_top)
  );

  always_comb begin
    win_d   = win_q;
    col_d   = col_q;
    valid_d = 1'b0;
    if (En) begin
      // Shift every row one column left, newest column enters on the right.
      for (int r = 0; r < 3; r++) begin
        win_d[(3*r)*DW   +: DW] = win_q[(3*r+1)*DW +: DW];
        win_d[(3*r+1)*DW +: DW] = win_q[(3*r+2)*DW +: DW];
      end
      win_d[W_TR*DW +: DW] = w_top;
      win_d[W_MR*DW +: DW] = w_mid;
      win_d[W_BR*DW +: DW] = Pixel_In;
      // Columns 0 and 1 straddle the previous row's tail.
      valid_d = Row_Valid & (col_q >= c_COL_TWO);
      col_d   = w_col_last ? '0 : col_q + c_ONE;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      win_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      col_q   <= col_d;
      valid_q <= valid_d;
    end
  end

  assign Window_Out   = win_q;
  assign Window_Valid = valid_q;

`ifdef CONV_WIN_FRAME_DONE_EN
  logic [CW-1:0] row_q,  row_d;
  logic          done_q, done_d;

  always_comb begin
    row_d  = row_q;
    done_d = 1'b0;
    if (En && w_col_last) begin
      row_d  = (row_q == c_LAST) ? '0 : row_q + c_ONE;
      done_d = (row_q == c_LAST);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      row_q  <= '0;
      done_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      done_q <= done_d;
    end
  end

  assign Frame_Done = done_q;
`else
  assign Frame_Done = 1'b0;
`endif

endmodule : conv_window_3x3
`default_nettype wire

// File: tb/tb_conv_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_3x3
// Description : Self-checking bench for conv_window_3x3 with a 4x4 image and
//               pixel value 4*row+col. Expected windows are queued when the
//               pixel is issued; a monitor pops and compares whenever the DUT
//               raises Window_Valid. Frame_Done expectations follow the
//               CONV_WIN_FRAME_DONE_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_3x3;
  import conv2d_pkg::*;

  localparam int IMG = 4;
  localparam int DW  = 8;
  localparam int CW  = 7;
`ifdef CONV_WIN_FRAME_DONE_EN
  localparam bit FD_EN = 1'b1;
`else
  localparam bit FD_EN = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Rst;
  logic           En;
  logic [DW-1:0]  Pixel_In;
  logic           Row_Valid;
  logic [9*DW-1:0] Window_Out;
  logic           Window_Valid;
  logic           Frame_Done;

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;
  logic [9*DW-1:0] exp_q [$];

  conv_window_3x3 #(
    .IMG_SIZE        (IMG),
    .DATA_WIDTH      (DW),
    .COL_COUNT_WIDTH (CW)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .En           (En),
    .Pixel_In     (Pixel_In),
    .Row_Valid    (Row_Valid),
    .Window_Out   (Window_Out),
    .Window_Valid (Window_Valid),
    .Frame_Done   (Frame_Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9*DW-1:0] win9(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Hand-computed interior windows of the 4x4 test image (k0..k8).
  function automatic logic [9*DW-1:0] hand_win(input int r, input int c);
    if (r == 2 && c == 2) return win9(0, 1, 2, 4, 5, 6, 8, 9, 10);
    if (r == 2 && c == 3) return win9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    if (r == 3 && c == 2) return win9(4, 5, 6, 8, 9, 10, 12, 13, 14);
    if (r == 3 && c == 3) return win9(5, 6, 7, 9, 10, 11, 13, 14, 15);
    return '0;
  endfunction

  // Issue one pixel; checks after the accepting edge.
  task automatic send(input int r, input int c, input bit rv);
    En        = 1'b1;
    Pixel_In  = 8'(4*r + c);
    Row_Valid = rv;
    if (rv && c >= 2) exp_q.push_back(hand_win(r, c));
    @(posedge Clk); #1;
    En = 1'b0;
    chk("valid", 72'(Window_Valid), 72'(rv && c >= 2));
    chk("shift_newest", 72'(win_elem(Window_Out, W_BR)), 72'(4*r + c));
    chk("frame_done", 72'(Frame_Done), 72'(FD_EN && r == IMG-1 && c == IMG-1));
  endtask

  task automatic stall3(input logic [9*DW-1:0] held);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("stall_hold", Window_Out, held);
      chk("stall_valid", 72'(Window_Valid), 72'(0));
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge Clk) begin
    if (Rst) begin
      if (Frame_Done) fd_count++;
      if (Window_Valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 72'(1), 72'(0));
        else chk("window", Window_Out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Rst = 1'b0; En = 1'b0; Pixel_In = '0; Row_Valid = 1'b0;
    #12;
    chk("reset_window", Window_Out, '0);
    chk("reset_valid", 72'(Window_Valid), 72'(0));
    chk("reset_frame_done", 72'(Frame_Done), 72'(0));
    @(negedge Clk); Rst = 1'b1;

    // Frame A: normal stream with a 3-cycle stall after pixel (2,2).
    for (int r = 0; r < IMG; r++) begin
      for (int c = 0; c < IMG; c++) begin
        send(r, c, r >= 2);
        if (r == 2 && c == 2) begin
          chk("win_2_2_direct", Window_Out, hand_win(2, 2));
          stall3(hand_win(2, 2));
        end
      end
    end

    // Frame B: Row_Valid never asserted, window still shifts.
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        send(r, c, 1'b0);

    // Frame C: reset mid-frame after pixel (1,2).
    for (int i = 0; i < 7; i++) send(i / IMG, i % IMG, 1'b0);
    #2 Rst = 1'b0;
    #2;
    chk("midreset_window", Window_Out, '0);
    chk("midreset_valid", 72'(Window_Valid), 72'(0));
    chk("midreset_frame_done", 72'(Frame_Done), 72'(0));
    @(negedge Clk); Rst = 1'b1;

    // Frame D: full new frame after the reset.
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        send(r, c, r >= 2);

    repeat (3) @(posedge Clk);
    #1;
    chk("queue_drained", 72'(exp_q.size()), 72'(0));
    chk("frame_done_count", 72'(fd_count), 72'(FD_EN ? 3 : 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_conv_window_3x3
`default_nettype wire

// File: doc/conv_window_3x3.md
Name: conv_window_3x3

Overview:
Streaming 3x3 window generator for the conv2d3x3 pipeline. It sits directly downstream of the pixel source and beside the row-counting stage, and feeds the MAC/convolution core.
- Accepts one raster-order pixel per enabled cycle.
- Keeps the two previous image rows in line buffers.
- Presents the current 3x3 neighbourhood as one flat word.
- Raises Window_Valid only when the window lies fully inside the image. The row-stage Row_Valid flag is combined with its own column count to decide this.

Parameters:
IMG_SIZE, 100, image width and height in pixels (square image)
DATA_WIDTH, 8, pixel width in bits
COL_COUNT_WIDTH, 7, width of the column and row counters; must satisfy 2^COL_COUNT_WIDTH > IMG_SIZE-1

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  asynchronous active-low reset
En  input  1  pixel strobe; Pixel_In is accepted on each rising edge where En=1
Pixel_In  input  DATA_WIDTH  current raster pixel
Row_Valid  input  1  row-stage flag sampled on the same edge as the pixel; 1 = current row is at least 2 and is a valid window row
Window_Out  output  9*DATA_WIDTH  window; element k=3*r+c occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]; r0=oldest row (top), c0=oldest column (left)
Window_Valid  output  1  one-cycle flag per accepted pixel; Window_Out is a legal interior window
Frame_Done  output  1  one-cycle pulse after the last pixel of a frame (see Optional Feature)

Behaviour:
- Reset (Rst=0, asynchronous):
  - Window registers, column counter, row counter, Window_Valid and Frame_Done all go to 0.
  - Line-buffer storage is not reset. Its stale contents are masked because Row_Valid/column gating keeps Window_Valid low.
- Accepted pixel (En=1) at column counter value c, performed on one edge:
  - mid = LB0[c] and top = LB1[c], read combinationally before the write.
  - LB1[c] <= LB0[c]; LB0[c] <= Pixel_In.
  - Window columns shift left: col0 <= col1, col1 <= col2, col2 <= {top, mid, Pixel_In} for rows r0, r1, r2.
  - Window_Valid <= Row_Valid & (c >= 2).
  - c <= (c == IMG_SIZE-1) ? 0 : c+1. The row counter increments when c wraps, and wraps to 0 after IMG_SIZE-1.
- Latency: Window_Out and Window_Valid are updated on the same edge that accepts the pixel, i.e. they are valid one cycle after the strobe is sampled.
- En=0 (stall):
  - All window registers, counters and line buffers hold.
  - Window_Valid <= 0 and Frame_Done <= 0. No duplicate valids are produced.
- Row boundary: for pixels at c=0 and c=1 the window straddles the previous row's tail. These are masked by c>=2 regardless of Row_Valid.
- Row_Valid=0 forces Window_Valid=0. The block never second-guesses the row stage.
- Frame wrap: after pixel (IMG_SIZE-1, IMG_SIZE-1) both counters return to 0. The next pixel is treated as (0,0).
- Reset mid-frame: counters restart at (0,0). The first valid window of the new frame appears at pixel (2,2), provided Row_Valid is asserted.
- Arithmetic is counters only. Compares are unsigned at COL_COUNT_WIDTH bits. No pixel arithmetic is performed.

Optional Feature:
- Macro: CONV_WIN_FRAME_DONE_EN.
- When defined:
  - The internal row counter is compiled in.
  - Frame_Done <= 1 for one cycle on the edge that accepts pixel (IMG_SIZE-1, IMG_SIZE-1), and is 0 otherwise.
- When undefined:
  - The row counter is removed.
  - Frame_Done is tied 1'b0.
  - All other behaviour is identical.

Decomposition:
- Shared package conv2d_pkg holds:
  - IMG_SIZE, DATA_WIDTH and COL_COUNT_WIDTH defaults.
  - Window element index constants (W_TL=0 … W_BR=8).
  - A window-element slice helper.
- One sub-module, conv_line_buffer: single row, IMG_SIZE x DATA_WIDTH, combinational read and synchronous write at a shared address. It is instantiated twice (LB0, LB1).

Test Plan:
All scenarios use IMG_SIZE=4, DATA_WIDTH=8, and pixel value = 4*row+col.
1. Reset, then stream a full frame with En=1 and Row_Valid driven high for rows 2–3 -> after pixel (2,2) is accepted, Window_Valid=1 and Window_Out = {0,1,2,4,5,6,8,9,10} (k0..k8).
2. Same stream, pixel (2,3) -> Window_Out = {1,2,3,5,6,7,9,10,11}, Window_Valid=1. Pixels (3,0) and (3,1) -> Window_Valid=0. Pixel (3,2) -> {4,5,6,8,9,10,12,13,14}, Window_Valid=1.
3. Stall: drop En for 3 cycles after pixel (2,2) -> Window_Out holds {0,1,2,4,5,6,8,9,10}, Window_Valid=0 for all 3 cycles. Resume -> pixel (2,3) gives the scenario-2 window, valid exactly once.
4. Row_Valid held 0 for the whole frame -> Window_Valid never asserts, while Window_Out still shifts per accepted pixel.
5. Rst pulsed low after pixel (1,2), then a new frame is streamed -> Window_Valid stays 0 until new-frame pixel (2,2). With CONV_WIN_FRAME_DONE_EN defined, Frame_Done pulses exactly once, after pixel index 15.
6. With CONV_WIN_FRAME_DONE_EN undefined, repeat scenario 5 -> Frame_Done remains 0 and Window_Out/Window_Valid match scenario 5 cycle for cycle.
